// File: rtl/div_share_sched_pkg.sv
// Shared types and constants for the shared-divider scheduler.
// Holds the FSM state enum, the response record and the id-width helper.
package div_sched_pkg;

    localparam int DATA_W = 32;

    // Quotient reported for a divide-by-zero answered without the divider
    localparam logic [DATA_W-1:0] ZERO_BYPASS_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        logic              err;
    } resp_t;

    // Width needed to encode n distinct values, never less than one bit
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/div_share_sched_if.sv
// Client and divider bus of the shared-divider scheduler.
// slave = scheduler side, master = clients plus divider instance.
interface div_share_sched_if #(
    parameter int N = 2
);
    import div_sched_pkg::*;

    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*DATA_W-1:0] req_dvnd;
    logic [N*DATA_W-1:0] req_dvsr;
    logic [N-1:0]        resp_valid;
    logic [N-1:0]        resp_ack;
    logic [DATA_W-1:0]   resp_q;
    logic [DATA_W-1:0]   resp_r;
    logic                resp_err;
    logic                div_run;
    logic [DATA_W-1:0]   div_dvnd;
    logic [DATA_W-1:0]   div_dvsr;
    logic                div_rdy;
    logic [DATA_W-1:0]   div_q;
    logic [DATA_W-1:0]   div_r;
    logic                busy;

    modport slave (
        input  req_valid, req_dvnd, req_dvsr, resp_ack, div_rdy, div_q, div_r,
        output req_ready, resp_valid, resp_q, resp_r, resp_err,
               div_run, div_dvnd, div_dvsr, busy
    );

    modport master (
        output req_valid, req_dvnd, req_dvsr, resp_ack, div_rdy, div_q, div_r,
        input  req_ready, resp_valid, resp_q, resp_r, resp_err,
               div_run, div_dvnd, div_dvsr, busy
    );

endinterface

// File: rtl/div_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps,
// first requester found wins (one-hot grant plus encoded id).
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    always_comb begin : p_arb
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[IDW'(idx)]) begin
                any              = 1'b1;
                gnt[IDW'(idx)]   = 1'b1;
                gnt_id           = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// Shares one iterative divider among N requesters with round-robin grant and a BUSY watchdog.
// Optional: DIV_SCHED_ZERO_BYPASS_EN answers dvsr==0 locally without starting the divider.
module div_share_sched
    import div_sched_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    div_share_sched_if.slave bus
);

    localparam int IDW = clog2(N);
    localparam int CW  = clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [DATA_W-1:0] dvnd_q, dvnd_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    resp_t             rsp_q, rsp_d;
    logic [N-1:0]      rvld_q, rvld_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [N-1:0]      gnt;
    logic [IDW-1:0]    gnt_id;
    logic              gnt_any;
    logic [N-1:0]      owner_oh;
    logic [DATA_W-1:0] dvnd_arr [N];
    logic [DATA_W-1:0] dvsr_arr [N];
    logic [DATA_W-1:0] dvnd_sel, dvsr_sel;

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign dvnd_arr[i] = bus.req_dvnd[i*DATA_W +: DATA_W];
        assign dvsr_arr[i] = bus.req_dvsr[i*DATA_W +: DATA_W];
    end

    assign dvnd_sel = dvnd_arr[gnt_id];
    assign dvsr_sel = dvsr_arr[gnt_id];
    assign owner_oh = N'(1) << owner_q;

    rr_arbiter #(.N(N)) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    // Grant is combinational in IDLE and forced low while reset is held
    assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        dvnd_d  = dvnd_q;
        dvsr_d  = dvsr_q;
        rsp_d   = rsp_q;
        rvld_d  = rvld_q;
        run_d   = 1'b0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    owner_d = gnt_id;
                    dvnd_d  = dvnd_sel;
                    dvsr_d  = dvsr_sel;
                    busy_d  = 1'b1;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
                    if (dvsr_sel == '0) begin
                        rsp_d   = '{q: ZERO_BYPASS_Q, r: dvnd_sel, err: 1'b0};
                        rvld_d  = gnt;
                        state_d = RESP;
                    end else begin
                        run_d   = 1'b1;
                        state_d = LAUNCH;
                    end
`else
                    run_d   = 1'b1;
                    state_d = LAUNCH;
`endif
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // A real result in the last watchdog cycle still wins
                if (bus.div_rdy) begin
                    rsp_d   = '{q: bus.div_q, r: bus.div_r, err: 1'b0};
                    rvld_d  = owner_oh;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_d   = '{q: '0, r: '0, err: 1'b1};
                    rvld_d  = owner_oh;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ack[owner_q]) begin
                    rvld_d  = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            dvnd_q  <= '0;
            dvsr_q  <= '0;
            rsp_q   <= '0;
            rvld_q  <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            dvnd_q  <= dvnd_d;
            dvsr_q  <= dvsr_d;
            rsp_q   <= rsp_d;
            rvld_q  <= rvld_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.resp_valid = rvld_q;
    assign bus.resp_q     = rsp_q.q;
    assign bus.resp_r     = rsp_q.r;
    assign bus.resp_err   = rsp_q.err;
    assign bus.div_run    = run_q;
    assign bus.div_dvnd   = dvnd_q;
    assign bus.div_dvsr   = dvsr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Directed/random bench for div_share_sched: the bench plays clients and divider,
// and predicts grants, results and response timing from a plain round-robin model.
module tb_div_share_sched;
    import div_sched_pkg::*;

    localparam int N  = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ptr_m = 0;
    int   wo;
    logic [31:0] opa [N];
    logic [31:0] opb [N];

    div_share_sched_if #(.N(N)) bus ();

    div_share_sched #(.N(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic int rr_win(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_dvnd[32*i +: 32] = opa[i];
            bus.req_dvsr[32*i +: 32] = opb[i];
        end
    endtask

    // One full operation: grant, launch, divider reply after lat BUSY cycles
    // (lat<0: never), ackd cycles in RESP before the owner acks.
    task automatic run_op(input logic [N-1:0] vm, input int lat, input int ackd,
                          input bit stray, input bit use_f, input logic [31:0] fa,
                          input logic [31:0] fb, output int w);
        logic [31:0] a, b, eq, er;
        logic [N-1:0] oh;
        bit ee, byp, seen;
        int t, exp_lat;
        w = rr_win(vm, ptr_m);
        oh = N'(1) << w;
        for (int i = 0; i < N; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom >> $urandom_range(0, 31);
            if (opb[i] == 0) opb[i] = 1;
        end
        if (use_f) begin
            opa[w] = fa;
            opb[w] = fb;
        end
        a = opa[w];
        b = opb[w];
`ifdef DIV_SCHED_ZERO_BYPASS_EN
        byp = (b == 0);
`else
        byp = 1'b0;
`endif
        if (b == 0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
        ee = (lat < 0) && !byp;
        if (ee) begin
            eq = 0;
            er = 0;
        end
        exp_lat = byp ? 1 : (lat < 0 ? TO + 2 : lat + 3);

        nxt();
        bus.req_valid = vm;
        drive_ops();
        smp();
        t = cyc;
        chk("grant", bus.req_ready, oh);
        chk("idle_busy", bus.busy, 0);

        seen = 1'b0;
        if (byp) begin
            nxt();
            smp();
            chk("byp_norun", bus.div_run, 0);
            seen = (bus.resp_valid != 0);
        end else begin
            nxt();
            if (stray) begin
                bus.div_rdy = 1'b1;
                bus.div_q   = $urandom;
                bus.div_r   = $urandom;
            end
            smp();
            chk("run_pulse", bus.div_run, 1);
            chk("run_dvnd", bus.div_dvnd, a);
            chk("run_dvsr", bus.div_dvsr, b);
            chk("launch_nogrant", bus.req_ready, 0);
            for (int k = 0; k < TO + 8 && !seen; k++) begin
                nxt();
                bus.div_rdy = (k == lat);
                bus.div_q   = (k == lat) ? eq : $urandom;
                bus.div_r   = (k == lat) ? er : $urandom;
                smp();
                chk("run_once", bus.div_run, 0);
                seen = (bus.resp_valid != 0);
            end
        end

        chk("resp_seen", seen, 1);
        chk("resp_lat", cyc - t, exp_lat);
        chk("resp_vld", bus.resp_valid, oh);
        chk("resp_q", bus.resp_q, eq);
        chk("resp_r", bus.resp_r, er);
        chk("resp_err", bus.resp_err, ee);
        chk("resp_busy", bus.busy, 1);
        chk("resp_nogrant", bus.req_ready, 0);
        if (!byp) begin
            chk("resp_dvnd", bus.div_dvnd, a);
            chk("resp_dvsr", bus.div_dvsr, b);
        end

        for (int d = 0; d < ackd; d++) begin
            nxt();
            if (stray) begin
                bus.resp_ack = ~oh;
                bus.div_rdy  = 1'b1;
                bus.div_q    = $urandom;
                bus.div_r    = $urandom;
            end
            smp();
            chk("hold_vld", bus.resp_valid, oh);
            chk("hold_q", bus.resp_q, eq);
            chk("hold_r", bus.resp_r, er);
            if (!byp) chk("hold_dvnd", bus.div_dvnd, a);
        end
        nxt();
        bus.resp_ack = oh;
        bus.div_rdy  = 1'b0;
        smp();
        chk("ack_vld", bus.resp_valid, oh);
        nxt();
        bus.resp_ack  = '0;
        bus.req_valid = '0;
        ptr_m = (w + 1) % N;
        smp();
        chk("post_ack_busy", bus.busy, 0);
        chk("post_ack_vld", bus.resp_valid, 0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_dvnd  = '0;
        bus.req_dvsr  = '0;
        bus.resp_ack  = '0;
        bus.div_rdy   = 1'b0;
        bus.div_q     = '0;
        bus.div_r     = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '1;
        smp();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_vld", bus.resp_valid, 0);
        chk("rst_run", bus.div_run, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dvnd", bus.div_dvnd, 0);
        chk("rst_q", bus.resp_q, 0);
        nxt();
        rst = 1'b0;
        bus.req_valid = '0;
        smp();

        // single op 100/7 with a 33-cycle divider
        run_op(2'b01, 33, 1, 1'b0, 1'b1, 32'd100, 32'd7, wo);
        chk("single_owner", wo, 0);

        // watchdog abort, then a normal op
        run_op(2'b10, -1, 2, 1'b0, 1'b0, 32'd0, 32'd0, wo);
        run_op(2'b11, 12, 0, 1'b0, 1'b0, 32'd0, 32'd0, wo);

        // reset ten cycles into BUSY
        nxt();
        opa[0] = $urandom | 32'h1;
        opb[0] = 32'd3;
        drive_ops();
        bus.req_valid = 2'b01;
        smp();
        chk("mid_grant", bus.req_ready, 2'b01);
        nxt();
        bus.req_valid = '0;
        smp();
        chk("mid_launch", bus.div_run, 1);
        repeat (11) nxt();
        bus.req_valid = '1;
        rst = 1'b1;
        #1;
        chk("arst_ready", bus.req_ready, 0);
        chk("arst_vld", bus.resp_valid, 0);
        chk("arst_q", bus.resp_q, 0);
        chk("arst_r", bus.resp_r, 0);
        chk("arst_err", bus.resp_err, 0);
        chk("arst_run", bus.div_run, 0);
        chk("arst_dvnd", bus.div_dvnd, 0);
        chk("arst_dvsr", bus.div_dvsr, 0);
        chk("arst_busy", bus.busy, 0);
        smp();
        nxt();
        rst = 1'b0;
        bus.req_valid = '0;
        ptr_m = 0;
        nxt();
        bus.div_rdy  = 1'b1;
        bus.div_q    = '1;
        bus.resp_ack = '1;
        smp();
        chk("late_rdy_busy", bus.busy, 0);
        chk("late_rdy_vld", bus.resp_valid, 0);
        nxt();
        bus.div_rdy  = 1'b0;
        bus.resp_ack = '0;
        smp();
        chk("late_rdy_vld2", bus.resp_valid, 0);
        chk("late_rdy_run", bus.div_run, 0);

        // fairness with both requesters asking every op
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, $urandom_range(0, 20), $urandom_range(0, 3), 1'b0, 1'b0, 32'd0, 32'd0, wo);
            chk("fair_order", wo, i % 2);
        end

        // stray ack / rdy, then a zero divisor
        run_op(2'b11, 20, 3, 1'b1, 1'b0, 32'd0, 32'd0, wo);
        run_op(2'b10, 10, 1, 1'b0, 1'b1, 32'h1234, 32'd0, wo);

        for (int i = 0; i < 8; i++) begin
            run_op(N'($urandom_range(1, 3)), $urandom_range(0, 45), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)), 1'b0, 32'd0, 32'd0, wo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
